// File: rtl/sram_1rw1r_param_model.sv
// rtl/sram_1rw1r_param_model.sv - parametrised 1RW+1R dual-port SRAM behavioural model
// Optional macro: SRAM_WRITE_THROUGH_EN (collision read on port 1 returns the newly written word)
module sram_1rw1r_param_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WMASK_WIDTH  = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1,
    parameter int VERBOSE      = 0
) (
    input  logic                   clk0,
    input  logic                   rstb0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dvalid1,
    output logic                   collide
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $fatal(1, "sram_1rw1r_param_model: DATA_WIDTH must be a multiple of 8");
        end
        if (WMASK_WIDTH * 8 != DATA_WIDTH) begin : g_bad_mask
            $fatal(1, "sram_1rw1r_param_model: WMASK_WIDTH must equal DATA_WIDTH/8");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "sram_1rw1r_param_model: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ctl_x0;
    logic                  ctl_x1;
    logic                  wr0;
    logic                  rv0;
    logic                  rv1;
    logic                  rc;
    logic [DATA_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] rd1;

    // Sampling-edge view of both ports; reads see the array before this edge's write.
    always_comb begin
        ctl_x0 = $isunknown({csb0, web0});
        ctl_x1 = $isunknown(csb1);
        wr0    = rstb0 && !csb0 && !web0;
        rv0    = rstb0 && !csb0 && web0;
        rv1    = rstb0 && !csb1;
        rc     = rv1 && wr0 && (addr0 == addr1);
        rd0    = mem[addr0];
        rd1    = mem[addr1];
`ifdef SRAM_WRITE_THROUGH_EN
        if (rc) begin
            for (int b = 0; b < WMASK_WIDTH; b++) begin
                if (wmask0[b]) rd1[8*b +: 8] = din0[8*b +: 8];
            end
        end
`endif
        if (rstb0 && ctl_x0) begin
            rv0 = 1'bx;
            rd0 = 'x;
        end
        if (rstb0 && ctl_x1) begin
            rv1 = 1'bx;
            rd1 = 'x;
            rc  = 1'bx;
        end
    end

    always_ff @(posedge clk0) begin
        if (wr0) begin
            for (int b = 0; b < WMASK_WIDTH; b++) begin
                if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end
        end
    end

    logic                  ov0;
    logic                  ov1;
    logic                  oc;
    logic [DATA_WIDTH-1:0] od0;
    logic [DATA_WIDTH-1:0] od1;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk0 or negedge rstb0) begin
                if (!rstb0) begin
                    ov0 <= 1'b0;
                    ov1 <= 1'b0;
                    oc  <= 1'b0;
                    od0 <= '0;
                    od1 <= '0;
                end else begin
                    ov0 <= rv0;
                    ov1 <= rv1;
                    oc  <= rc;
                    od0 <= rd0;
                    od1 <= rd1;
                end
            end
        end else begin : g_lat1
            assign ov0 = rv0;
            assign ov1 = rv1;
            assign oc  = rc;
            assign od0 = rd0;
            assign od1 = rd1;
        end
    endgenerate

    // dout only moves on a (possibly unknown) valid, so deselected ports hold their last word.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            dvalid0 <= 1'b0;
            dvalid1 <= 1'b0;
            collide <= 1'b0;
            dout0   <= '0;
            dout1   <= '0;
        end else begin
            dvalid0 <= ov0;
            dvalid1 <= ov1;
            collide <= oc;
            if (ov0 !== 1'b0) dout0 <= od0;
            if (ov1 !== 1'b0) dout1 <= od1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk0) begin
        if (rstb0) begin
            if (ctl_x0 || ctl_x1)
                $display("WARNING: %m unknown chip select / write enable at %0t", $time);
            if (rc === 1'b1)
                $display("WARNING: %m port0 write / port1 read collision at addr %h, %0t", addr1, $time);
            if (VERBOSE != 0) begin
                if (wr0)
                    $display("%m: write addr %h data %h mask %b", addr0, din0, wmask0);
                if (rv0 === 1'b1)
                    $display("%m: port0 read addr %h", addr0);
                if (rv1 === 1'b1)
                    $display("%m: port1 read addr %h", addr1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_sram_1rw1r_param_model.sv
// tb/tb_sram_1rw1r_param_model.sv - vector-table bench driving latency-1 and latency-2 instances in parallel
module tb_sram_1rw1r_param_model;
    logic        clk = 1'b0;
    logic        rstb0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;

    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_dvalid0, a_dvalid1, a_collide, b_dvalid0, b_dvalid1, b_collide;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_1rw1r_param_model #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(1), .VERBOSE(0)) u_lat1 (
        .clk0(clk), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(a_dout0), .dvalid0(a_dvalid0), .csb1(csb1), .addr1(addr1), .dout1(a_dout1),
        .dvalid1(a_dvalid1), .collide(a_collide));

    sram_1rw1r_param_model #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(2), .VERBOSE(0)) u_lat2 (
        .clk0(clk), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(b_dout0), .dvalid0(b_dvalid0), .csb1(csb1), .addr1(addr1), .dout1(b_dout1),
        .dvalid1(b_dvalid1), .collide(b_collide));

    typedef struct {
        logic        cs0;
        logic        we0;
        logic [3:0]  m;
        logic [7:0]  a0;
        logic [31:0] di;
        logic        cs1;
        logic [7:0]  a1;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        c;
    } vec_t;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        c;
    } exp_t;

`ifdef SRAM_WRITE_THROUGH_EN
    localparam logic [31:0] COL_DATA = 32'h1234_5678;
`else
    localparam logic [31:0] COL_DATA = 32'h0000_0000;
`endif

    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input exp_t e);
        chk({tag, " lat1 dvalid0"}, {31'd0, a_dvalid0}, {31'd0, e.v0});
        chk({tag, " lat1 dout0"}, a_dout0, e.d0);
        chk({tag, " lat1 dvalid1"}, {31'd0, a_dvalid1}, {31'd0, e.v1});
        chk({tag, " lat1 dout1"}, a_dout1, e.d1);
        chk({tag, " lat1 collide"}, {31'd0, a_collide}, {31'd0, e.c});
    endtask

    task automatic chk_b(input string tag, input exp_t e);
        chk({tag, " lat2 dvalid0"}, {31'd0, b_dvalid0}, {31'd0, e.v0});
        chk({tag, " lat2 dout0"}, b_dout0, e.d0);
        chk({tag, " lat2 dvalid1"}, {31'd0, b_dvalid1}, {31'd0, e.v1});
        chk({tag, " lat2 dout1"}, b_dout1, e.d1);
        chk({tag, " lat2 collide"}, {31'd0, b_collide}, {31'd0, e.c});
    endtask

    function automatic vec_t mk(logic cs0, logic we0, logic [3:0] m, logic [7:0] a0, logic [31:0] di,
                                logic cs1, logic [7:0] a1, logic v0, logic [31:0] d0,
                                logic v1, logic [31:0] d1, logic c);
        vec_t r;
        r.cs0 = cs0; r.we0 = we0; r.m = m; r.a0 = a0; r.di = di; r.cs1 = cs1; r.a1 = a1;
        r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1; r.c = c;
        return r;
    endfunction

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h00; din0 = 32'h0; csb1 = 1'b1; addr1 = 8'h00;
    endtask

    initial begin
        exp_t zero;
        exp_t cur;
        exp_t prev;
        zero = '{v0: 1'b0, d0: 32'h0, v1: 1'b0, d1: 32'h0, c: 1'b0};

        //            cs0  we0  m     a0     din            cs1  a1     v0  d0             v1  d1             c
        vt[0]  = mk(1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        vt[1]  = mk(1'b0, 1'b1, 4'h0, 8'h10, 32'h00000000, 1'b1, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0);
        vt[2]  = mk(1'b0, 1'b0, 4'hF, 8'h11, 32'h11223344, 1'b1, 8'h00, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 4'h5, 8'h11, 32'hAABBCCDD, 1'b1, 8'h00, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0);
        vt[4]  = mk(1'b0, 1'b1, 4'h0, 8'h11, 32'h00000000, 1'b0, 8'h10, 1'b1, 32'h11BB33DD, 1'b1, 32'hDEADBEEF, 1'b0);
        vt[5]  = mk(1'b0, 1'b0, 4'hF, 8'h20, 32'h00000000, 1'b1, 8'h00, 1'b0, 32'h11BB33DD, 1'b0, 32'hDEADBEEF, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 4'hF, 8'h20, 32'h12345678, 1'b0, 8'h20, 1'b0, 32'h11BB33DD, 1'b1, COL_DATA,      1'b1);
        vt[7]  = mk(1'b0, 1'b1, 4'h0, 8'h20, 32'h00000000, 1'b0, 8'h20, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 4'h0, 8'h10, 32'h00000000, 1'b1, 8'h00, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 4'h8, 8'h11, 32'h55667788, 1'b0, 8'h10, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0);
        vt[10] = mk(1'b1, 1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h11, 1'b0, 32'h12345678, 1'b1, 32'h55BB33DD, 1'b0);
        vt[11] = mk(1'b1, 1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h10, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0);
        vt[12] = mk(1'b1, 1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h20, 1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b0);
        vt[13] = mk(1'b1, 1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h11, 1'b0, 32'h12345678, 1'b1, 32'h55BB33DD, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 4'hF, 8'h30, 32'hCAFEF00D, 1'b1, 8'h00, 1'b0, 32'h12345678, 1'b0, 32'h55BB33DD, 1'b0);
        vt[15] = mk(1'b0, 1'b1, 4'h0, 8'h30, 32'h00000000, 1'b1, 8'h00, 1'b1, 32'hCAFEF00D, 1'b0, 32'h55BB33DD, 1'b0);
        for (int i = 16; i < 21; i++)
            vt[i] = mk(1'b1, 1'b1, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h00, 1'b0, 32'hCAFEF00D, 1'b0, 32'h55BB33DD, 1'b0);

        // Reset state: outputs cleared while rstb0 is held low across clock edges.
        rstb0 = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk_a("reset", zero);
        chk_b("reset", zero);
        rstb0 = 1'b1;

        // The latency-2 instance must reproduce the latency-1 outputs exactly one cycle later.
        prev = zero;
        for (int i = 0; i < 21; i++) begin
            csb0 = vt[i].cs0; web0 = vt[i].we0; wmask0 = vt[i].m; addr0 = vt[i].a0; din0 = vt[i].di;
            csb1 = vt[i].cs1; addr1 = vt[i].a1;
            @(posedge clk);
            #1;
            cur = '{v0: vt[i].v0, d0: vt[i].d0, v1: vt[i].v1, d1: vt[i].d1, c: vt[i].c};
            chk_a($sformatf("vec%0d", i), cur);
            chk_b($sformatf("vec%0d", i), prev);
            prev = cur;
        end

        // Reset asserted with reads in flight: outputs clear at once.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h30; csb1 = 1'b0; addr1 = 8'h11;
        @(posedge clk);
        #1;
        rstb0 = 1'b0;
        #1;
        chk_a("midreset", zero);
        chk_b("midreset", zero);

        // Write attempted while in reset must not commit.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h30; din0 = 32'hBAD0BAD0; csb1 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_a("inreset", zero);
            chk_b("inreset", zero);
        end
        idle();
        rstb0 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_a("postreset", zero);
            chk_b("postreset", zero);
        end

        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h30;
        @(posedge clk);
        #1;
        idle();
        chk_a("readback1", '{v0: 1'b1, d0: 32'hCAFEF00D, v1: 1'b0, d1: 32'h0, c: 1'b0});
        chk_b("readback1", zero);
        @(posedge clk);
        #1;
        chk_a("readback2", '{v0: 1'b0, d0: 32'hCAFEF00D, v1: 1'b0, d1: 32'h0, c: 1'b0});
        chk_b("readback2", '{v0: 1'b1, d0: 32'hCAFEF00D, v1: 1'b0, d1: 32'h0, c: 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
